sync_debounce_edge: RTL and testbench
=====================================

Name: sync_debounce_edge

Overview:
- Consumes the single-bit output of the multi-flop synchronizer, already in the clk domain.
- Filters glitches by requiring DEBOUNCE_CYCLES consecutive equal samples before the output level changes.
- Emits single-cycle rise/fall pulses and keeps a wrapping count of rising events.
- Sits between the synchronizer and control logic that needs clean levels and edges.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive equal samples needed to accept a new level; legal range >= 2.
- CNT_W, 5: width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- EVENT_W, 8: width of the rising-event counter.

Ports:
- clk  in  1: single clock; all logic is posedge clk.
- rstn  in  1: reset, asynchronous assert, active-low; all flops clear immediately when rstn=0.
- sync_sig_i  in  1: synchronized input from the synchronizer stage.
- evt_clr_i  in  1: synchronous clear of evt_cnt_o.
- level_o  out  1: debounced level.
- rise_o  out  1: one-cycle pulse when level_o goes 0->1.
- fall_o  out  1: one-cycle pulse when level_o goes 1->0.
- evt_cnt_o  out  EVENT_W: count of accepted rising edges; wraps modulo 2^EVENT_W.

Behaviour:
- Reset values: state=STABLE_LOW, cnt=0, level_o=0, rise_o=0, fall_o=0, evt_cnt_o=0.
- All outputs are registered. There is no combinational path from input to output.
- FSM states: STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW.
- STABLE_LOW:
  - sync_sig_i=1 -> WAIT_HIGH, cnt<=1.
  - Otherwise stay, cnt<=0.
- WAIT_HIGH:
  - sync_sig_i=0 -> STABLE_LOW, cnt<=0. This is a glitch; level_o is unchanged.
  - sync_sig_i=1 and cnt==DEBOUNCE_CYCLES-1 -> STABLE_HIGH, level_o<=1, rise_o<=1, cnt<=0.
  - sync_sig_i=1 otherwise -> cnt<=cnt+1.
- STABLE_HIGH and WAIT_LOW mirror the two states above with polarity inverted. Acceptance sets level_o<=0 and fall_o<=1.
- Latency: input first sampled at the new value on edge k gives level_o and the pulse updated at edge k+DEBOUNCE_CYCLES-1.
- Runt inputs: a run of exactly DEBOUNCE_CYCLES-1 samples never propagates.
- rise_o and fall_o:
  - Each is high for exactly one cycle and deasserts on the next edge unconditionally.
  - They are never high together.
  - Minimum spacing between any two pulses is DEBOUNCE_CYCLES cycles.
- evt_cnt_o:
  - Increments on the same edge that sets rise_o.
  - 2^EVENT_W-1 + 1 -> 0, with no sticky flag.
- evt_clr_i:
  - Alone: evt_cnt_o<=0.
  - Coincident with an acceptance edge: evt_cnt_o<=1. The clear applies first, then the increment.
- Reset mid-operation: async clear to the reset values. Any partial debounce count is discarded, and no pulse is emitted as a result of the reset.
- After reset release, if sync_sig_i=1 the block must still debounce it (full DEBOUNCE_CYCLES) before level_o=1.

Optional Feature:
- Macro: SYNC_DEBOUNCE_GLITCH_CNT_EN.
- When defined:
  - Adds output glitch_cnt_o [7:0].
  - Increments on every WAIT_HIGH->STABLE_LOW or WAIT_LOW->STABLE_HIGH abort.
  - Saturates at 255.
  - Cleared by rstn and by evt_clr_i; if a clear and an abort coincide, the result is 1.
- When undefined: the port and the logic are absent. All other behaviour is identical.

Test Plan (DEBOUNCE_CYCLES=4, EVENT_W=8):
- Reset then hold sync_sig_i=0 for 20 cycles -> level_o=0, rise_o=fall_o=0, evt_cnt_o=0 throughout.
- sync_sig_i 0->1 sampled at edge k, held -> level_o=1 and rise_o=1 at edge k+3; rise_o=0 at k+4; evt_cnt_o=1.
- With level_o=1, apply a low pulse of 3 cycles then return high -> no fall_o, level_o stays 1. With the macro defined, glitch_cnt_o=1.
- 256 accepted rising edges with no clear -> evt_cnt_o wraps to 0. Assert evt_clr_i on the acceptance edge of the 257th rise -> evt_cnt_o=1.
- Hold high 2 cycles into WAIT_HIGH, drop rstn for 1 cycle mid-count (async, off-edge) -> outputs 0 immediately. Input held high after release -> level_o=1 exactly 4 sampled-high edges after release.
- Alternate accepted high and low runs of 4 cycles each -> rise_o and fall_o alternate, each 1 cycle wide, spaced 4 cycles apart, never overlapping.

Source files
------------

// File: rtl/sync_debounce_edge.sv
// sync_debounce_edge
//   Debounces a single-bit, already-synchronized input. A new level is
//   accepted only after DEBOUNCE_CYCLES consecutive equal samples. The block
//   emits one-cycle rise/fall pulses on acceptance and keeps a wrapping count
//   of accepted rising edges, clearable through evt_clr_i.
//
//   Optional build macro: SYNC_DEBOUNCE_GLITCH_CNT_EN
//     When defined, adds glitch_cnt_o[7:0]. This saturating counter records
//     every aborted debounce attempt and is cleared by evt_clr_i.
//     When undefined, that port and its logic are absent.
//
//   All outputs come straight from flops. There is no combinational path
//   from any input to any output.
module sync_debounce_edge #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 5,
  parameter int unsigned EVENT_W         = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               sync_sig_i,
  input  logic               evt_clr_i,
  output logic               level_o,
  output logic               rise_o,
  output logic               fall_o,
  output logic [EVENT_W-1:0] evt_cnt_o
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [7:0]         glitch_cnt_o
`endif
);

  // Debounce FSM encoding
  localparam logic [1:0] STABLE_LOW  = 2'd0;
  localparam logic [1:0] WAIT_HIGH   = 2'd1;
  localparam logic [1:0] STABLE_HIGH = 2'd2;
  localparam logic [1:0] WAIT_LOW    = 2'd3;

  // The count holds the number of consecutive samples seen at the candidate
  // level. Acceptance happens on the sample that would make it DEBOUNCE_CYCLES.
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [EVENT_W-1:0] EVT_ONE  = EVENT_W'(1);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               level_q, level_d;
  logic               rise_q,  rise_d;
  logic               fall_q,  fall_d;
  logic [EVENT_W-1:0] evt_q,   evt_d;

  // Strobes decoded from the FSM for the current sample
  logic accept_rise;
  logic accept_fall;
  logic abort;

  // Next-state decode: qualify each sample against the candidate level
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    level_d     = level_q;
    accept_rise = 1'b0;
    accept_fall = 1'b0;
    abort       = 1'b0;
    case (state_q)
      STABLE_LOW: begin
        if (sync_sig_i) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!sync_sig_i) begin
          // The high run was too short, so it is a glitch. The level holds.
          state_d = STABLE_LOW;
          cnt_d   = '0;
          abort   = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = STABLE_HIGH;
          cnt_d       = '0;
          level_d     = 1'b1;
          accept_rise = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_HIGH: begin
        if (!sync_sig_i) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (sync_sig_i) begin
          // The low run was too short, so it is a glitch. The level holds.
          state_d = STABLE_HIGH;
          cnt_d   = '0;
          abort   = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = STABLE_LOW;
          cnt_d       = '0;
          level_d     = 1'b0;
          accept_fall = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LOW;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  // Pulses last exactly one cycle because they simply mirror the acceptance strobes
  always_comb begin
    rise_d = accept_rise;
    fall_d = accept_fall;
  end

  // Rising-event counter: the clear is applied first, then the increment,
  // so a coincident clear and acceptance leaves a count of 1
  always_comb begin
    evt_d = evt_q;
    if (evt_clr_i) begin
      evt_d = '0;
    end
    if (accept_rise) begin
      evt_d = evt_d + EVT_ONE;
    end
  end

  // FSM and debounce counter state; reset discards any partial count
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= STABLE_LOW;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered level and edge pulses; reset never produces a pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Rising-event counter register, which wraps naturally at 2^EVENT_W
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      evt_q <= '0;
    end else begin
      evt_q <= evt_d;
    end
  end

  assign level_o   = level_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
  assign evt_cnt_o = evt_q;

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_q, glitch_d;

  // Glitch counter: clear first, then a saturating increment on abort
  always_comb begin
    glitch_d = glitch_q;
    if (evt_clr_i) begin
      glitch_d = '0;
    end
    if (abort && (glitch_d != 8'hFF)) begin
      glitch_d = glitch_d + 8'd1;
    end
  end

  // Glitch counter register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      glitch_q <= '0;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign glitch_cnt_o = glitch_q;
`else
  // Without the glitch counter, the abort strobe has no consumer.
  logic unused_abort;
  assign unused_abort = abort;
`endif

endmodule

// File: tb/tb_sync_debounce_edge.sv
// Testbench for sync_debounce_edge with DEBOUNCE_CYCLES=4 and EVENT_W=8.
// The reference model tracks the length of the current run of samples that
// disagree with the accepted level. The level flips once that run reaches
// DEBOUNCE_CYCLES.
`timescale 1ns/1ps
module tb_sync_debounce_edge;
  localparam int DBC = 4;
  localparam int CW  = 3;
  localparam int EW  = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          sync_sig_i = 1'b0;
  logic          evt_clr_i = 1'b0;
  logic          level_o;
  logic          rise_o;
  logic          fall_o;
  logic [EW-1:0] evt_cnt_o;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  logic [7:0]    glitch_cnt_o;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model state
  logic          m_level;
  logic          m_rise;
  logic          m_fall;
  logic [EW-1:0] m_evt;
  int            m_run;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  int            m_glitch;
`endif

  sync_debounce_edge #(
    .DEBOUNCE_CYCLES(DBC),
    .CNT_W(CW),
    .EVENT_W(EW)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .sync_sig_i(sync_sig_i),
    .evt_clr_i(evt_clr_i),
    .level_o(level_o),
    .rise_o(rise_o),
    .fall_o(fall_o),
    .evt_cnt_o(evt_cnt_o)
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_cnt_o(glitch_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [EW+2:0] pack_dut();
    return {level_o, rise_o, fall_o, evt_cnt_o};
  endfunction

  function automatic logic [EW+2:0] pack_model();
    return {m_level, m_rise, m_fall, m_evt};
  endfunction

  task automatic model_reset();
    m_level = 1'b0;
    m_rise  = 1'b0;
    m_fall  = 1'b0;
    m_evt   = '0;
    m_run   = 0;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    m_glitch = 0;
`endif
  endtask

  // Advances the model by one sampled clock edge.
  task automatic model_step(input logic s, input logic c);
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    bit ab;
    ab = 1'b0;
`endif
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (s != m_level) begin
      m_run++;
      if (m_run == DBC) begin
        m_level = s;
        m_run   = 0;
        if (s) m_rise = 1'b1;
        else   m_fall = 1'b1;
      end
    end else begin
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
      if (m_run != 0) ab = 1'b1;
`endif
      m_run = 0;
    end
    if (c) m_evt = '0;
    if (m_rise) m_evt = m_evt + EW'(1);
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    if (c) m_glitch = 0;
    if (ab && m_glitch < 255) m_glitch++;
`endif
  endtask

  // Drives the inputs at the negedge, steps the model, and returns 1 ns after the posedge.
  task automatic tick(input logic s, input logic c);
    @(negedge clk);
    sync_sig_i = s;
    evt_clr_i  = c;
    model_step(s, c);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    sync_sig_i = 1'b0;
    evt_clr_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (pack_dut() !== '0) begin
      miscompares++;
      $display("FAIL reset_values: got %h want 0", pack_dut());
    end
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b0);
      vectors++;
      if (pack_dut() !== pack_model() || pack_dut() !== '0) begin
        miscompares++;
        $display("FAIL reset_hold_low cyc=%0d: got %h want %h", cyc, pack_dut(), pack_model());
      end
    end
  endtask

  task automatic test_rise_latency();
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0);
      vectors++;
      if ({level_o, rise_o, fall_o} !== {(i >= 3), (i == 3), 1'b0} || pack_dut() !== pack_model()) begin
        miscompares++;
        $display("FAIL rise_latency k+%0d: got lvl/rise/fall=%b%b%b want %b%b0 (dut %h model %h)",
                 i, level_o, rise_o, fall_o, (i >= 3), (i == 3), pack_dut(), pack_model());
      end
    end
    vectors++;
    if (evt_cnt_o !== 8'd1) begin
      miscompares++;
      $display("FAIL rise_evt_cnt: got %0d want 1", evt_cnt_o);
    end
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 7; i++) begin
      tick((i >= 3), 1'b0);
      vectors++;
      if (level_o !== 1'b1 || fall_o !== 1'b0 || pack_dut() !== pack_model()) begin
        miscompares++;
        $display("FAIL runt_low cyc=%0d: got lvl=%b fall=%b want lvl=1 fall=0 (dut %h model %h)",
                 cyc, level_o, fall_o, pack_dut(), pack_model());
      end
    end
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    vectors++;
    if (glitch_cnt_o !== 8'd1 || glitch_cnt_o !== 8'(m_glitch)) begin
      miscompares++;
      $display("FAIL glitch_cnt: got %0d want 1", glitch_cnt_o);
    end
`endif
  endtask

  task automatic test_evt_wrap();
    tick(1'b1, 1'b1);
    vectors++;
    if (evt_cnt_o !== 8'd0) begin
      miscompares++;
      $display("FAIL evt_clear_alone: got %0d want 0", evt_cnt_o);
    end
    for (int n = 0; n < 256; n++) begin
      for (int i = 0; i < 2 * DBC; i++) begin
        tick((i >= DBC), 1'b0);
        vectors++;
        if (pack_dut() !== pack_model()) begin
          miscompares++;
          $display("FAIL wrap_run n=%0d i=%0d: got %h want %h", n, i, pack_dut(), pack_model());
        end
      end
    end
    vectors++;
    if (evt_cnt_o !== 8'd0) begin
      miscompares++;
      $display("FAIL evt_wrap: got %0d want 0", evt_cnt_o);
    end
    for (int i = 0; i < 2 * DBC; i++) begin
      tick((i >= DBC), (i == 2 * DBC - 1));
    end
    vectors++;
    if (evt_cnt_o !== 8'd1 || rise_o !== 1'b1 || pack_dut() !== pack_model()) begin
      miscompares++;
      $display("FAIL evt_clr_with_rise: got evt=%0d rise=%b want evt=1 rise=1", evt_cnt_o, rise_o);
    end
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    vectors++;
    if (glitch_cnt_o !== 8'(m_glitch)) begin
      miscompares++;
      $display("FAIL glitch_after_clear: got %0d want %0d", glitch_cnt_o, m_glitch);
    end
`endif
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (pack_dut() !== '0) begin
      miscompares++;
      $display("FAIL async_reset_mid: got %h want 0", pack_dut());
    end
    @(posedge clk);
    #3;
    rstn = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick(1'b1, 1'b0);
      vectors++;
      if ({level_o, rise_o, fall_o} !== {(i >= 4), (i == 4), 1'b0} || pack_dut() !== pack_model()) begin
        miscompares++;
        $display("FAIL post_reset_debounce edge %0d: got lvl/rise/fall=%b%b%b want %b%b0",
                 i, level_o, rise_o, fall_o, (i >= 4), (i == 4));
      end
    end
  endtask

  task automatic test_back_to_back();
    int last;
    last = -1;
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < DBC; i++) begin
        tick(n[0], 1'b0);
        vectors++;
        if (pack_dut() !== pack_model() || (rise_o && fall_o)) begin
          miscompares++;
          $display("FAIL alternate cyc=%0d: got %h want %h", cyc, pack_dut(), pack_model());
        end
        if (rise_o || fall_o) begin
          if (last >= 0) begin
            vectors++;
            if (cyc - last !== DBC) begin
              miscompares++;
              $display("FAIL pulse_spacing cyc=%0d: got %0d want %0d", cyc, cyc - last, DBC);
            end
          end
          last = cyc;
        end
      end
    end
  endtask

  task automatic test_random();
    int last;
    logic v;
    int len;
    last = -100;
    for (int r = 0; r < 150; r++) begin
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++) begin
        tick(v, ($urandom_range(0, 15) == 0));
        vectors++;
        if (pack_dut() !== pack_model() || (rise_o && fall_o)) begin
          miscompares++;
          $display("FAIL random cyc=%0d: got %h want %h", cyc, pack_dut(), pack_model());
        end
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
        vectors++;
        if (glitch_cnt_o !== 8'(m_glitch)) begin
          miscompares++;
          $display("FAIL random_glitch cyc=%0d: got %0d want %0d", cyc, glitch_cnt_o, m_glitch);
        end
`endif
        if (rise_o || fall_o) begin
          vectors++;
          if (cyc - last < DBC) begin
            miscompares++;
            $display("FAIL random_spacing cyc=%0d: got %0d want >=%0d", cyc, cyc - last, DBC);
          end
          last = cyc;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rise_latency();
    test_glitch();
    test_evt_wrap();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
